// File: rtl/bus_arbiter_sched.sv
// Two-master (IFU/LSU) shared-bus arbiter with grant lock, timeout abort and an
// optional IFU anti-starvation guard enabled by defining ARB_STARVE_GUARD_EN.
module bus_arbiter_sched #(
   parameter int STARVE_LIMIT   = 4,
   parameter int TIMEOUT_CYCLES = 1023,
   parameter int TO_W           = 10
) (
   input  logic clk,
   input  logic rst,
   input  logic ifu_req,
   input  logic lsu_req,
   input  logic s_arvalid,
   input  logic s_arready,
   input  logic s_awvalid,
   input  logic s_awready,
   input  logic s_rvalid,
   input  logic s_rready,
   input  logic s_bvalid,
   input  logic s_bready,
   output logic ifu_gnt,
   output logic lsu_gnt,
   output logic bus_sel,
   output logic bus_busy,
   output logic timeout_err
);

   typedef enum logic [1:0] {IDLE = 2'd0, ADDR = 2'd1, RESP = 2'd2} state_t;

   state_t          state;
   logic [TO_W-1:0] to_cnt;
   logic            addr_hs;
   logic            resp_hs;
   logic            owner_req;
   logic            timeout_hit;
   logic            done;
   logic            abort_to;
   logic            abandon;
   logic            pick_lsu;

   assign addr_hs     = (s_arvalid & s_arready) | (s_awvalid & s_awready);
   assign resp_hs     = (s_rvalid & s_rready) | (s_bvalid & s_bready);
   assign owner_req   = bus_sel ? lsu_req : ifu_req;
   assign timeout_hit = (to_cnt >= TO_W'(TIMEOUT_CYCLES - 1));

   // Completion outranks the timeout; an address handshake alone does not.
   assign done     = ((state == ADDR) && addr_hs && resp_hs) || ((state == RESP) && resp_hs);
   assign abort_to = (state != IDLE) && !done && timeout_hit;
   assign abandon  = (state == ADDR) && !addr_hs && !owner_req && !abort_to;

`ifdef ARB_STARVE_GUARD_EN
   localparam int SC_W = $clog2(STARVE_LIMIT + 1);

   logic [SC_W-1:0] starve_cnt;
   logic            lsu_over_ifu;

   assign pick_lsu = lsu_req && !(ifu_req && (starve_cnt == SC_W'(STARVE_LIMIT)));

   // Counts only LSU transactions that completed while IFU was kept waiting.
   always_ff @(posedge clk) begin
      if (rst) begin
         starve_cnt   <= '0;
         lsu_over_ifu <= 1'b0;
      end else if (state == IDLE) begin
         if (!ifu_req || !pick_lsu) starve_cnt <= '0;
         lsu_over_ifu <= pick_lsu && ifu_req;
      end else if (done && lsu_gnt && lsu_over_ifu) begin
         starve_cnt <= starve_cnt + SC_W'(1);
      end
   end
`else
   assign pick_lsu = lsu_req;
`endif

   // NOTE: state and outputs are updated only with <= so every read in this block sees pre-edge values.
   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= IDLE;
         to_cnt      <= '0;
         ifu_gnt     <= 1'b0;
         lsu_gnt     <= 1'b0;
         bus_sel     <= 1'b0;
         bus_busy    <= 1'b0;
         timeout_err <= 1'b0;
      end else begin
         timeout_err <= 1'b0;
         if (state != IDLE) to_cnt <= to_cnt + TO_W'(1);

         if (done || abort_to || abandon) begin
            state       <= IDLE;
            ifu_gnt     <= 1'b0;
            lsu_gnt     <= 1'b0;
            bus_busy    <= 1'b0;
            timeout_err <= abort_to;
         end else begin
            case (state)
               IDLE: begin
                  if (ifu_req || lsu_req) begin
                     state    <= ADDR;
                     to_cnt   <= '0;
                     bus_sel  <= pick_lsu;
                     lsu_gnt  <= pick_lsu;
                     ifu_gnt  <= !pick_lsu;
                     bus_busy <= 1'b1;
                  end
               end
               ADDR: begin
                  if (addr_hs) state <= RESP;
               end
               RESP: begin
                  state <= RESP;
               end
               default: state <= IDLE;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_bus_arbiter_sched.sv
// Self-checking bench for bus_arbiter_sched: directed vector table, grant-order
// sequences and randomized traffic against a transaction-level reference model.
module tb_bus_arbiter_sched;

   localparam int STARVE = 4;
   localparam int TMO    = 8;
`ifdef ARB_STARVE_GUARD_EN
   localparam bit GUARD = 1'b1;
`else
   localparam bit GUARD = 1'b0;
`endif

   logic clk = 1'b0;
   logic rst, ifu_req, lsu_req;
   logic s_arvalid, s_arready, s_awvalid, s_awready;
   logic s_rvalid, s_rready, s_bvalid, s_bready;
   logic ifu_gnt, lsu_gnt, bus_sel, bus_busy, timeout_err;
   logic [4:0] outs;

   assign outs = {ifu_gnt, lsu_gnt, bus_sel, bus_busy, timeout_err};

   int n_checks = 0;
   int n_pass   = 0;

   bus_arbiter_sched #(
      .STARVE_LIMIT  (STARVE),
      .TIMEOUT_CYCLES(TMO),
      .TO_W          (10)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .ifu_req    (ifu_req),
      .lsu_req    (lsu_req),
      .s_arvalid  (s_arvalid),
      .s_arready  (s_arready),
      .s_awvalid  (s_awvalid),
      .s_awready  (s_awready),
      .s_rvalid   (s_rvalid),
      .s_rready   (s_rready),
      .s_bvalid   (s_bvalid),
      .s_bready   (s_bready),
      .ifu_gnt    (ifu_gnt),
      .lsu_gnt    (lsu_gnt),
      .bus_sel    (bus_sel),
      .bus_busy   (bus_busy),
      .timeout_err(timeout_err)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: run exceeded its time budget (checks %0d)", n_checks);
      $fatal(1, "watchdog expired");
   end

   // Reference model: who owns the bus, whether its address was accepted,
   // how long it has held the bus, and how often IFU has been passed over.
   int m_owner = 0;   // 0 none, 1 IFU, 2 LSU
   bit m_addr_ok = 1'b0;
   bit m_sel = 1'b0;
   bit m_err = 1'b0;
   bit m_waited = 1'b0;
   int m_age = 0;
   int m_starve = 0;

   function automatic logic [4:0] model_outs();
      return {m_owner == 1, m_owner == 2, m_sel, m_owner != 0, m_err};
   endfunction

   task automatic model_update();
      bit ahs, rhs, finished;
      int win;
      ahs   = (s_arvalid && s_arready) || (s_awvalid && s_awready);
      rhs   = (s_rvalid && s_rready) || (s_bvalid && s_bready);
      m_err = 1'b0;
      if (rst) begin
         m_owner = 0; m_addr_ok = 0; m_sel = 0; m_age = 0; m_starve = 0; m_waited = 0;
      end else if (m_owner == 0) begin
         if (ifu_req || lsu_req) begin
            win       = (lsu_req && !(GUARD && ifu_req && m_starve == STARVE)) ? 2 : 1;
            m_owner   = win;
            m_addr_ok = 1'b0;
            m_age     = 0;
            m_sel     = (win == 2);
            m_waited  = (win == 2) && ifu_req;
         end
         if (!ifu_req || m_owner == 1) m_starve = 0;
      end else begin
         m_age++;
         finished = rhs && (m_addr_ok || ahs);
         if (finished) begin
            if (m_owner == 2 && m_waited) m_starve++;
            m_owner = 0;
         end else if (m_age >= TMO) begin
            m_owner = 0;
            m_err   = 1'b1;
         end else if (ahs) begin
            m_addr_ok = 1'b1;
         end else if (!m_addr_ok && !(m_owner == 1 ? ifu_req : lsu_req)) begin
            m_owner = 0;
         end
      end
   endtask

   task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %b, expected %b", name, act, exp);
   endtask

   task automatic drive(input logic r_, i_, l_, ar_, aw_, rr_, bb_);
      rst = r_; ifu_req = i_; lsu_req = l_;
      s_arvalid = ar_; s_arready = ar_;
      s_awvalid = aw_; s_awready = aw_;
      s_rvalid  = rr_; s_rready  = rr_;
      s_bvalid  = bb_; s_bready  = bb_;
   endtask

   task automatic tick();
      model_update();
      @(posedge clk);
      #1;
   endtask

   typedef struct {
      string      name;
      logic       r, i, l, ar, aw, rr, bb;
      logic [4:0] exp;   // {ifu_gnt, lsu_gnt, bus_sel, bus_busy, timeout_err} after the edge
   } vec_t;

   vec_t vecs[$];

   task automatic add(input string nm, input logic r_, i_, l_, ar_, aw_, rr_, bb_,
                      input logic [4:0] e);
      vec_t v;
      v.name = nm; v.r = r_; v.i = i_; v.l = l_;
      v.ar = ar_; v.aw = aw_; v.rr = rr_; v.bb = bb_; v.exp = e;
      vecs.push_back(v);
   endtask

   byte grants[$];
   int  n_want;
   bit  prev_gnt;
   byte e_ch;
   int  dens;
   int  d_tbl[3] = '{5, 30, 70};

   initial begin
      drive(1, 0, 0, 0, 0, 0, 0);

      add("reset0", 1, 0, 0, 0, 0, 0, 0, 5'b00000);
      add("reset1", 1, 0, 0, 0, 0, 0, 0, 5'b00000);
      // IFU alone: AR at cycle 2, R at cycle 5, request dropped while locked in RESP
      add("ifu_c0", 0, 1, 0, 0, 0, 0, 0, 5'b10010);
      add("ifu_c1", 0, 1, 0, 0, 0, 0, 0, 5'b10010);
      add("ifu_c2", 0, 1, 0, 1, 0, 0, 0, 5'b10010);
      add("ifu_c3", 0, 0, 0, 0, 0, 0, 0, 5'b10010);
      add("ifu_c4", 0, 0, 0, 0, 0, 0, 0, 5'b10010);
      add("ifu_c5", 0, 0, 0, 0, 0, 1, 0, 5'b00000);
      add("ifu_c6", 0, 0, 0, 0, 0, 0, 0, 5'b00000);
      // Both request: LSU wins; same-cycle addr+resp completes; owner drop abandons
      add("prio_both", 0, 1, 1, 0, 0, 0, 0, 5'b01110);
      add("prio_ar_r", 0, 1, 1, 1, 0, 1, 0, 5'b00100);
      add("prio_again", 0, 1, 1, 0, 0, 0, 0, 5'b01110);
      add("prio_drop", 0, 1, 0, 0, 0, 0, 0, 5'b00100);
      add("prio_ifu", 0, 1, 0, 0, 0, 0, 0, 5'b10010);
      add("prio_aw", 0, 1, 0, 0, 1, 0, 0, 5'b10010);
      add("prio_b", 0, 0, 0, 0, 0, 0, 1, 5'b00000);
      // Timeout: AR accepted, no response
      add("tmo_c0", 0, 0, 1, 0, 0, 0, 0, 5'b01110);
      add("tmo_c1", 0, 0, 1, 1, 0, 0, 0, 5'b01110);
      for (int k = 0; k < 6; k++) add("tmo_wait", 0, 0, 0, 0, 0, 0, 0, 5'b01110);
      add("tmo_pulse", 0, 0, 0, 0, 0, 0, 0, 5'b00101);
      add("tmo_next", 0, 1, 0, 0, 0, 0, 0, 5'b10010);
      add("tmo_done", 0, 1, 0, 1, 0, 1, 0, 5'b00000);
      // Completion in the timeout cycle wins
      add("win_c0", 0, 0, 1, 0, 0, 0, 0, 5'b01110);
      add("win_c1", 0, 0, 1, 1, 0, 0, 0, 5'b01110);
      for (int k = 0; k < 6; k++) add("win_wait", 0, 0, 1, 0, 0, 0, 0, 5'b01110);
      add("win_resp", 0, 0, 0, 0, 0, 1, 0, 5'b00100);
      // Reset while in RESP
      add("rst_c0", 0, 0, 1, 0, 0, 0, 0, 5'b01110);
      add("rst_c1", 0, 0, 1, 0, 1, 0, 0, 5'b01110);
      add("rst_hit", 1, 0, 1, 0, 0, 0, 0, 5'b00000);
      add("rst_regrant", 0, 0, 1, 0, 0, 0, 0, 5'b01110);
      add("rst_done", 0, 0, 0, 1, 0, 1, 0, 5'b00100);

      foreach (vecs[k]) begin
         drive(vecs[k].r, vecs[k].i, vecs[k].l, vecs[k].ar, vecs[k].aw, vecs[k].rr, vecs[k].bb);
         tick();
         check(vecs[k].name, 8'(outs), 8'(vecs[k].exp));
      end

      // Both requests held, every transaction completes in its ADDR cycle
      drive(1, 0, 0, 0, 0, 0, 0);
      tick();
      tick();
      drive(0, 1, 1, 1, 0, 1, 0);
      n_want   = GUARD ? 10 : 20;
      prev_gnt = 1'b0;
      for (int c = 0; c < 200 && grants.size() < n_want; c++) begin
         tick();
         check("starve_model", 8'(outs), 8'(model_outs()));
         if ((ifu_gnt || lsu_gnt) && !prev_gnt) grants.push_back(lsu_gnt ? 8'h4c : 8'h49);
         prev_gnt = ifu_gnt || lsu_gnt;
      end
      check("grant_count", 8'(grants.size()), 8'(n_want));
      foreach (grants[k]) begin
         if (GUARD && (k % 5 == 4)) e_ch = "I";
         else e_ch = "L";
         check("grant_order", grants[k], e_ch);
      end

      // Randomized traffic against the model
      drive(1, 0, 0, 0, 0, 0, 0);
      tick();
      tick();
      dens = 30;
      for (int c = 0; c < 1500; c++) begin
         if (c % 64 == 0) dens = d_tbl[$urandom_range(0, 2)];
         rst       = ($urandom_range(0, 149) == 0);
         ifu_req   = ($urandom_range(0, 3) != 0);
         lsu_req   = ($urandom_range(0, 1) == 1);
         s_arvalid = ($urandom_range(0, 99) < dens);
         s_arready = ($urandom_range(0, 99) < 70);
         s_awvalid = ($urandom_range(0, 99) < dens);
         s_awready = ($urandom_range(0, 99) < 70);
         s_rvalid  = ($urandom_range(0, 99) < dens);
         s_rready  = ($urandom_range(0, 99) < 70);
         s_bvalid  = ($urandom_range(0, 99) < dens);
         s_bready  = ($urandom_range(0, 99) < 70);
         tick();
         check("random", 8'(outs), 8'(model_outs()));
      end

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/bus_arbiter_sched.md
BUS_ARBITER_SCHED -- requirements
Module: bus_arbiter_sched

Interface
REQ-001 SHALL have parameter STARVE_LIMIT, default 4: consecutive LSU grants allowed while IFU waits.
REQ-002 SHALL have parameter TIMEOUT_CYCLES, default 1023: max cycles a grant is held without completing.
REQ-003 SHALL have parameter TO_W, default 10: width of the timeout counter.
REQ-004 clk  in  1  sole clock; all state updates on rising edge.
REQ-005 rst  in  1  reset; synchronous, active-high.
REQ-006 ifu_req  in  1  IFU requests the shared memory bus.
REQ-007 lsu_req  in  1  LSU requests the shared memory bus.
REQ-008 s_arvalid, s_arready, s_awvalid, s_awready  in  1 each  observed slave-side address handshakes.
REQ-009 s_rvalid, s_rready, s_bvalid, s_bready  in  1 each  observed slave-side response handshakes.
REQ-010 ifu_gnt  out  1  IFU owns the bus (registered).
REQ-011 lsu_gnt  out  1  LSU owns the bus (registered).
REQ-012 bus_sel  out  1  mux select for the datapath: 0 = IFU, 1 = LSU; holds last value in IDLE.
REQ-013 bus_busy  out  1  high in ADDR and RESP states.
REQ-014 timeout_err  out  1  single-cycle pulse on a timeout abort.

Function
REQ-015 SHALL implement states IDLE, ADDR, RESP; ifu_gnt and lsu_gnt are never both high.
REQ-016 IDLE: if either request is high, SHALL pick a winner, assert its gnt, set bus_sel, and enter ADDR on the next edge (1-cycle grant latency).
REQ-017 Default arbitration SHALL give LSU priority over IFU.
REQ-018 ADDR: SHALL enter RESP on (s_arvalid&s_arready)|(s_awvalid&s_awready).
REQ-019 ADDR: if the owner's req drops before an address handshake, SHALL return to IDLE with gnt deasserted, and SHALL NOT count a grant.
REQ-020 Address and response handshakes in the same ADDR cycle SHALL complete the transaction and go directly to IDLE.
REQ-021 RESP: SHALL go to IDLE on the first (s_rvalid&s_rready)|(s_bvalid&s_bready); requests are ignored until then (grant locked).
REQ-022 Simultaneous AR and AW handshakes SHALL be treated as one transaction.
REQ-023 After completion, SHALL spend exactly one IDLE cycle with both gnt low before re-arbitrating.
REQ-024 Timeout counter SHALL clear on entry to ADDR and increment each cycle in ADDR/RESP.
REQ-025 When the timeout counter reaches TIMEOUT_CYCLES, SHALL pulse timeout_err for 1 cycle, drop gnt, and enter IDLE.
REQ-026 A completion in the same cycle as the timeout SHALL win; no timeout_err is raised.

Reset
REQ-027 While rst=1 the block SHALL be in IDLE with ifu_gnt=0, lsu_gnt=0, bus_sel=0, bus_busy=0, timeout_err=0, and all counters 0.
REQ-028 Reset mid-transaction SHALL abort without a timeout_err pulse; the first grant is possible one cycle after rst falls.

Configuration
REQ-029 With ARB_STARVE_GUARD_EN defined, SHALL count completed LSU transactions granted while ifu_req was high.
REQ-030 The count SHALL clear on an IFU grant or an IDLE cycle with ifu_req low.
REQ-031 When the count equals STARVE_LIMIT and ifu_req is high, the next arbitration SHALL grant IFU.
REQ-032 Without ARB_STARVE_GUARD_EN, SHALL use strict LSU priority and contain no starvation counter.

Verification
REQ-033 Only ifu_req=1; AR handshake at cycle 2, R handshake at cycle 5 -> ifu_gnt high cycles 1-5, bus_sel=0, IDLE at cycle 6.
REQ-034 ifu_req=lsu_req=1 simultaneously from IDLE -> lsu_gnt=1, bus_sel=1, ifu_gnt=0.
REQ-035 Guard enabled, STARVE_LIMIT=4, both requests held continuously -> grant order L,L,L,L,I,L,L,L,L,I.
REQ-036 Guard disabled, same stimulus -> IFU never granted over 20 transactions.
REQ-037 TIMEOUT_CYCLES=8, AR handshake then no R response -> timeout_err pulses 8 cycles after ADDR entry, gnt drops, next request served.
REQ-038 rst pulsed while in RESP -> outputs zero next cycle, no timeout_err; lsu_req then granted 1 cycle after rst falls.
